// File: rtl/mult_div_unit_if.sv
// Bus between the EX-stage decode/forwarding logic and the multiply/divide unit.
// The pipeline drives the master side and the unit implements the slave side.
interface mult_div_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_req;

    modport master (
        output start, op, rs_data, rt_data, rd_sel,
        input  rd_data, hi, lo, busy, stall_req
    );

    modport slave (
        input  start, op, rs_data, rt_data, rd_sel,
        output rd_data, hi, lo, busy, stall_req
    );
endinterface

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run for a fixed latency; MTHI/MTLO complete in one cycle.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV   = CNT_W'(DIV_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;      // bit1: divide, bit0: unsigned
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_is_div;
    logic             w_is_signed;
    logic [63:0]      w_prod;
    logic [31:0]      w_a_mag;
    logic [31:0]      w_b_mag;
    logic [31:0]      w_q_mag;
    logic [31:0]      w_r_mag;
    logic [31:0]      w_hi_res;
    logic [31:0]      w_lo_res;
    logic             w_wr_en;

    assign w_is_div    = r_op[1];
    assign w_is_signed = ~r_op[0];

    // Sign-extending to 64 bits lets a single truncated multiply cover both flavours.
    assign w_prod = w_is_signed
                  ? ({{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b})
                  : ({32'd0, r_a} * {32'd0, r_b});

    // Signed divide works on magnitudes, which also makes 0x80000000 / -1 wrap cleanly.
    assign w_a_mag = (w_is_signed && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_b_mag = (w_is_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_hi_res = w_prod[63:32];
        w_lo_res = w_prod[31:0];
        w_wr_en  = 1'b1;
        if (w_is_div) begin
            w_lo_res = (w_is_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
            w_hi_res = (w_is_signed && r_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;
            w_wr_en  = (r_b != 32'd0);
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_state == ST_IDLE) begin
            if (md.start) begin
                if (!md.op[2]) begin
                    r_op    <= md.op[1:0];
                    r_a     <= md.rs_data;
                    r_b     <= md.rt_data;
                    r_cnt   <= md.op[1] ? CNT_DIV : CNT_MULT;
                    r_state <= ST_RUN;
                end else if (md.op == OP_MTHI) begin
                    r_hi <= md.rs_data;
                end else if (md.op == OP_MTLO) begin
                    r_lo <= md.rs_data;
                end
            end
        end else begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
                r_state <= ST_IDLE;
                if (w_wr_en) begin
                    r_hi <= w_hi_res;
                    r_lo <= w_lo_res;
                end
            end
        end
    end

    assign md.busy      = (r_state == ST_RUN);
    assign md.stall_req = md.busy | (md.start & ~md.op[2]);
    assign md.hi        = r_hi;
    assign md.lo        = r_lo;
    assign md.rd_data   = md.rd_sel ? r_hi : r_lo;

endmodule
